// File: rtl/pram_pkg.sv
// pram_pkg: PRAM sizing, owner and mode encodings shared by the arbiter and init controller
package pram_pkg;
  localparam int unsigned PRAM_BYTES = 32'h4000;
  localparam int unsigned STARVE_MAX = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;
  typedef enum logic {MODE_BOOT, MODE_RUN} mode_e;
  function automatic logic in_range(input logic [31:0] a, input int unsigned lim);
    return a < lim;
  endfunction
endpackage

// File: rtl/pram_rr_starve.sv
// pram_rr_starve: LS-priority arbiter between IF and LS with a saturating IF starve counter
module pram_rr_starve #(
  parameter int unsigned STARVE_MAX = pram_pkg::STARVE_MAX
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       if_req_i,
  input  logic       ls_req_i,
  output logic [1:0] gnt_o
);
  import pram_pkg::*;
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic starved, if_w, ls_w;
  always_comb begin
    starved = cnt_q == CW'(STARVE_MAX);
    if_w = en_i & if_req_i & (~ls_req_i | starved);
    ls_w = en_i & ls_req_i & ~if_w;
    gnt_o = {ls_w, if_w};
    cnt_d = (!en_i || !if_req_i || if_w) ? '0 : starved ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pram_arbiter.sv
// pram_arbiter: shares the single-port PRAM between boot load, instruction fetch and load/store
module pram_arbiter #(
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 32,
  parameter int unsigned PRAM_BYTES = pram_pkg::PRAM_BYTES,
  parameter int unsigned STARVE_MAX = pram_pkg::STARVE_MAX
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                load_when_reset,
  input  logic                boot_valid,
  input  logic [ADDR_W-1:0]   boot_addr,
  input  logic [DATA_W-1:0]   boot_wdata,
  output logic                boot_ack,
  output logic                boot_err,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                pram_en,
  output logic [DATA_W/8-1:0] pram_we,
  output logic [ADDR_W-3:0]   pram_addr,
  output logic [DATA_W-1:0]   pram_wdata,
  input  logic [DATA_W-1:0]   pram_rdata
);
  import pram_pkg::*;
  mode_e mode_q, mode_d;
  owner_e owner_q, owner_d;
  logic err_q, err_d, boot_err_q, boot_err_d;
  logic boot_m, run_m, boot_in, if_in, ls_in;
  logic [1:0] gnt;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_BOOT;
    else mode_q <= mode_d;
  end
  always_comb mode_d = load_when_reset ? MODE_BOOT : MODE_RUN;
  // reset gates both modes so no grant can escape while rst_n is low
  always_comb begin
    boot_m = rst_n && mode_q == MODE_BOOT;
    run_m = rst_n && mode_q == MODE_RUN;
  end
  always_comb begin
    boot_in = in_range(32'(boot_addr), PRAM_BYTES);
    if_in = in_range(32'(if_addr), PRAM_BYTES);
    ls_in = in_range(32'(ls_addr), PRAM_BYTES);
  end
  pram_rr_starve #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .en_i     (run_m),
    .if_req_i (if_req),
    .ls_req_i (ls_req),
    .gnt_o    (gnt)
  );
  always_comb begin
    boot_ack = boot_m & boot_valid;
    if_gnt = gnt[0];
    ls_gnt = gnt[1];
    pram_en = (boot_ack & boot_in) | (if_gnt & if_in) | (ls_gnt & ls_in);
    pram_we = (boot_ack & boot_in) ? '1 : (ls_gnt & ls_in & ls_we) ? ls_be : '0;
    pram_addr = boot_m ? boot_addr[ADDR_W-1:2] : ls_gnt ? ls_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
    pram_wdata = boot_m ? boot_wdata : ls_wdata;
  end
  always_comb begin
    owner_d = if_gnt ? OWN_IF : ls_gnt ? OWN_LS : OWN_NONE;
    err_d = (if_gnt & ~if_in) | (ls_gnt & ~ls_in);
    boot_err_d = boot_ack & ~boot_in;
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      err_q <= 1'b0;
      boot_err_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q <= err_d;
      boot_err_q <= boot_err_d;
    end
  end
  // an out-of-range access never touched PRAM, so its response data is forced to zero
  always_comb begin
    if_rvalid = owner_q == OWN_IF;
    ls_rvalid = owner_q == OWN_LS;
    ls_err = ls_rvalid & err_q;
    boot_err = boot_err_q;
    if_rdata = (if_rvalid & ~err_q) ? pram_rdata : '0;
    ls_rdata = (ls_rvalid & ~err_q) ? pram_rdata : '0;
  end
endmodule

// File: tb/tb_pram_arbiter.sv
// tb_pram_arbiter: vector table, directed corner cases and random traffic against a PRAM reference model
module tb_pram_arbiter;
  localparam int SM = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic load_when_reset, boot_valid, if_req, ls_req, ls_we;
  logic [15:0] boot_addr, if_addr, ls_addr;
  logic [31:0] boot_wdata, ls_wdata, if_rdata, ls_rdata, pram_wdata, pram_rdata;
  logic [3:0] ls_be, pram_we;
  logic [13:0] pram_addr;
  logic boot_ack, boot_err, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, pram_en;
  always #5 clk = ~clk;

  pram_arbiter dut (
    .clk_i(clk), .rst_n(rst_n), .load_when_reset(load_when_reset),
    .boot_valid(boot_valid), .boot_addr(boot_addr), .boot_wdata(boot_wdata),
    .boot_ack(boot_ack), .boot_err(boot_err),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .pram_en(pram_en), .pram_we(pram_we), .pram_addr(pram_addr), .pram_wdata(pram_wdata),
    .pram_rdata(pram_rdata)
  );

  // PRAM macro stand-in: byte-write, 1-cycle read latency
  logic [31:0] mem [16384];
  always @(posedge clk) begin
    if (pram_en) begin
      if (pram_we == 4'b0) pram_rdata <= mem[pram_addr];
      for (int b = 0; b < 4; b++) if (pram_we[b]) mem[pram_addr][8*b +: 8] <= pram_wdata[8*b +: 8];
    end
  end

  int checks = 0, failures = 0;
  int starve;
  bit m_boot, pv_if, pv_ls, p_err, p_berr, p_chk;
  logic [31:0] p_data;
  logic [31:0] ref_mem [4096];

  typedef struct { bit ir; bit lr; bit eg_if; bit eg_ls; } vec_t;
  vec_t tv [12];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  function automatic bit inr(input logic [15:0] a);
    return a < 16'h4000;
  endfunction

  function automatic logic [15:0] raddr();
    return ($urandom_range(0, 9) == 0) ? 16'(16'h4000 + $urandom_range(0, 16'hbfff)) : 16'($urandom_range(0, 16'h3fff));
  endfunction

  task automatic idle();
    boot_valid = 0; boot_addr = 0; boot_wdata = 0;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
  endtask

  task automatic model_reset();
    m_boot = 1; pv_if = 0; pv_ls = 0; p_err = 0; p_berr = 0; p_chk = 0; p_data = 0; starve = 0;
  endtask

  // one clock of the reference model; entered at posedge+1 with inputs applied, leaves at next posedge+1
  task automatic cycle();
    bit iw = 0, lw = 0, e_en = 0;
    bit n_if = 0, n_ls = 0, n_err = 0, n_berr = 0, n_chk = 0;
    logic [31:0] n_data = 0;
    logic [3:0] e_we = 0;
    logic [13:0] e_addr = 0;
    #3;
    chk("if_rvalid", if_rvalid, pv_if);
    chk("ls_rvalid", ls_rvalid, pv_ls);
    chk("ls_err", ls_err, pv_ls & p_err);
    chk("boot_err", boot_err, p_berr);
    if (pv_if) chk("if_rdata", if_rdata, p_data);
    if (pv_ls && p_chk) chk("ls_rdata", ls_rdata, p_data);
    if (m_boot) begin
      chk("boot_ack", boot_ack, boot_valid);
      starve = 0;
      if (boot_valid && inr(boot_addr)) begin
        e_en = 1; e_we = 4'hf; e_addr = boot_addr[15:2];
        ref_mem[boot_addr[13:2]] = boot_wdata;
      end
      n_berr = boot_valid && !inr(boot_addr);
    end else begin
      chk("boot_ack", boot_ack, 0);
      iw = if_req && (!ls_req || starve == SM);
      lw = ls_req && !iw;
      starve = (if_req && !iw) ? (starve < SM ? starve + 1 : SM) : 0;
      if (iw) begin
        n_if = 1; n_err = !inr(if_addr); n_chk = 1;
        e_en = !n_err; e_addr = if_addr[15:2];
        n_data = n_err ? 32'h0 : ref_mem[if_addr[13:2]];
      end
      if (lw) begin
        n_ls = 1; n_err = !inr(ls_addr); n_chk = !ls_we || n_err;
        e_en = !n_err; e_addr = ls_addr[15:2];
        n_data = n_err ? 32'h0 : ref_mem[ls_addr[13:2]];
        if (ls_we && !n_err) begin
          e_we = ls_be;
          for (int b = 0; b < 4; b++) if (ls_be[b]) ref_mem[ls_addr[13:2]][8*b +: 8] = ls_wdata[8*b +: 8];
        end
      end
    end
    chk("if_gnt", if_gnt, iw);
    chk("ls_gnt", ls_gnt, lw);
    chk("pram_en", pram_en, e_en);
    chk("pram_we", pram_we, e_we);
    if (e_en) chk("pram_addr", pram_addr, e_addr);
    if (e_we != 0) chk("pram_wdata", pram_wdata, m_boot ? boot_wdata : ls_wdata);
    @(posedge clk); #1;
    m_boot = load_when_reset;
    pv_if = n_if; pv_ls = n_ls; p_err = n_err; p_berr = n_berr; p_chk = n_chk; p_data = n_data;
  endtask

  initial begin
    tv[0]  = '{1, 1, 0, 1}; tv[1]  = '{1, 1, 0, 1}; tv[2]  = '{1, 1, 0, 1}; tv[3]  = '{1, 1, 0, 1};
    tv[4]  = '{1, 1, 1, 0}; tv[5]  = '{1, 1, 0, 1}; tv[6]  = '{1, 0, 1, 0}; tv[7]  = '{0, 1, 0, 1};
    tv[8]  = '{1, 1, 0, 1}; tv[9]  = '{0, 0, 0, 0}; tv[10] = '{1, 1, 0, 1}; tv[11] = '{1, 0, 1, 0};
    idle();
    load_when_reset = 1;
    boot_valid = 1; if_req = 1; ls_req = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_boot_ack", boot_ack, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_ls_rvalid", ls_rvalid, 0);
    chk("rst_ls_err", ls_err, 0);
    chk("rst_boot_err", boot_err, 0);
    chk("rst_pram_en", pram_en, 0);
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;

    // boot fill with IF and LS requesting throughout
    for (int n = 0; n < 4096; n++) begin
      boot_valid = 1; boot_addr = 16'(4 * n); boot_wdata = 32'(4 * n);
      cycle();
    end
    for (int n = 0; n < 4096; n++) if (mem[n] !== 32'(4 * n)) chk("boot_fill_word", mem[n], 32'(4 * n));
    chk("boot_fill_last", mem[4095], 32'h3ffc);

    boot_addr = 16'h4000; boot_wdata = 32'hdead_beef;
    #2;
    chk("boot_oor_ack", boot_ack, 1);
    chk("boot_oor_en", pram_en, 0);
    cycle();
    idle();
    #2;
    chk("boot_oor_err", boot_err, 1);
    cycle();

    load_when_reset = 0;
    cycle();
    cycle();
    for (int i = 0; i < 12; i++) begin
      if_req = tv[i].ir; ls_req = tv[i].lr; ls_we = 0;
      if_addr = 16'(4 * i); ls_addr = 16'(16'h200 + 4 * i);
      #2;
      chk("tbl_if_gnt", if_gnt, tv[i].eg_if);
      chk("tbl_ls_gnt", ls_gnt, tv[i].eg_ls);
      cycle();
    end

    idle();
    ls_req = 1; ls_we = 1; ls_be = 4'hf; ls_addr = 16'h0100; ls_wdata = 32'h1122_3344;
    cycle();
    ls_be = 4'b0010; ls_wdata = 32'haabb_ccdd;
    #2;
    chk("store_rvalid", ls_rvalid, 1);
    chk("store_err", ls_err, 0);
    cycle();
    ls_we = 0; ls_be = 0;
    cycle();
    idle();
    #2;
    chk("byte_store_load", ls_rdata, 32'h1122_cc44);
    cycle();

    ls_req = 1; ls_addr = 16'h8000;
    #2;
    chk("ls_err_gnt", ls_gnt, 1);
    chk("ls_err_en", pram_en, 0);
    cycle();
    idle();
    #2;
    chk("ls_err_rvalid", ls_rvalid, 1);
    chk("ls_err_flag", ls_err, 1);
    chk("ls_err_rdata", ls_rdata, 0);
    cycle();

    for (int i = 0; i < 3000; i++) begin
      load_when_reset = $urandom_range(0, 99) < 3;
      boot_valid = $urandom_range(0, 1); boot_addr = raddr(); boot_wdata = $urandom;
      if_req = $urandom_range(0, 3) != 0; if_addr = raddr();
      ls_req = $urandom_range(0, 2) != 0; ls_we = $urandom_range(0, 1);
      ls_be = 4'($urandom); ls_addr = raddr(); ls_wdata = $urandom;
      cycle();
    end

    idle();
    load_when_reset = 0;
    cycle();
    cycle();
    if_req = 1; if_addr = 16'h0010;
    #2;
    chk("mid_rst_if_gnt", if_gnt, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_gnt_gated", if_gnt, 0);
    @(posedge clk); #1;
    chk("mid_rst_if_rvalid", if_rvalid, 0);
    idle();
    load_when_reset = 1;
    @(posedge clk); #1;
    rst_n = 1;
    #2;
    chk("post_rst_boot_ack", boot_ack, 0);
    chk("post_rst_if_rvalid", if_rvalid, 0);
    chk("post_rst_ls_rvalid", ls_rvalid, 0);
    chk("post_rst_ls_err", ls_err, 0);
    chk("post_rst_boot_err", boot_err, 0);
    chk("post_rst_pram_en", pram_en, 0);
    if_req = 1; ls_req = 1;
    #1;
    chk("post_rst_if_gnt", if_gnt, 0);
    chk("post_rst_ls_gnt", ls_gnt, 0);
    @(posedge clk); #1;
    model_reset();
    idle();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
